// File: rtl/div_rem_collect_if.sv
// Bus between the last div/rem step stage, the collect block and the writeback consumer.
// The master side drives step results and resp_ready; the slave side returns the FIFO head.
interface div_rem_collect_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CORE_W = 3,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              ready_in;
  logic              rem_or_div_in;
  logic              sign_state_in;
  logic [CORE_W-1:0] core_num_in;
  logic [WIDTH-1:0]  quotient_in;
  logic [WIDTH-1:0]  remainder_in;
  logic              resp_valid;
  logic              resp_ready;
  logic [CORE_W-1:0] resp_core;
  logic [WIDTH-1:0]  resp_data;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              overflow;

  modport master (
    output ready_in, rem_or_div_in, sign_state_in, core_num_in, quotient_in, remainder_in,
    output resp_ready,
    input  resp_valid, resp_core, resp_data, count, full, overflow
  );

  modport slave (
    input  ready_in, rem_or_div_in, sign_state_in, core_num_in, quotient_in, remainder_in,
    input  resp_ready,
    output resp_valid, resp_core, resp_data, count, full, overflow
  );
endinterface

// File: rtl/div_rem_collect.sv
// Output end of the DIV/REM pipeline: selects quotient/remainder, applies sign fix,
// and queues results in a small FIFO with a valid/ready handshake toward the core.
module div_rem_collect #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CORE_W = 3,
  parameter int unsigned DEPTH  = 4
) (
  input logic             clk,
  input logic             reset,
  div_rem_collect_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic              cap_valid_q, cap_valid_d;
  logic [CORE_W-1:0] cap_core_q, cap_core_d;
  logic [WIDTH-1:0]  cap_data_q, cap_data_d;
  logic [WIDTH-1:0]  sel_c;

  logic [WIDTH-1:0]  mem_data_q [DEPTH];
  logic [CORE_W-1:0] mem_core_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;

  logic not_empty_c, full_c, push_c, pop_c, push_ok_c;

  // Capture stage: pick the requested result and negate it when the sign fix is needed.
  always_comb begin
    sel_c       = bus.rem_or_div_in ? bus.remainder_in : bus.quotient_in;
    cap_valid_d = bus.ready_in;
    cap_core_d  = cap_core_q;
    cap_data_d  = cap_data_q;
    if (bus.ready_in) begin
      cap_core_d = bus.core_num_in;
      cap_data_d = bus.sign_state_in ? (~sel_c + WIDTH'(1)) : sel_c;
    end
  end

  // FIFO control: a push into a full queue only lands if the head leaves in the same cycle.
  always_comb begin
    not_empty_c = (count_q != '0);
    full_c      = (count_q == CNT_W'(DEPTH));
    push_c      = cap_valid_q;
    pop_c       = not_empty_c && bus.resp_ready;
    push_ok_c   = push_c && (!full_c || pop_c);
    wr_ptr_d    = push_ok_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d     = count_q + CNT_W'(push_ok_c) - CNT_W'(pop_c);
    overflow_d  = overflow_q || (push_c && !push_ok_c);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_valid_q <= 1'b0;
      cap_core_q  <= '0;
      cap_data_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      cap_valid_q <= cap_valid_d;
      cap_core_q  <= cap_core_d;
      cap_data_q  <= cap_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage needs no reset: entries are only observable while count says they are valid.
  always_ff @(posedge clk) begin
    if (!reset && push_ok_c) begin
      mem_data_q[wr_ptr_q] <= cap_data_q;
      mem_core_q[wr_ptr_q] <= cap_core_q;
    end
  end

  assign bus.resp_valid = not_empty_c;
  assign bus.resp_core  = not_empty_c ? mem_core_q[rd_ptr_q] : '0;
  assign bus.resp_data  = not_empty_c ? mem_data_q[rd_ptr_q] : '0;
  assign bus.count      = count_q;
  assign bus.full       = full_c;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_div_rem_collect.sv
// Bench for div_rem_collect: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_div_rem_collect;
  localparam int unsigned WIDTH  = 32;
  localparam int unsigned CORE_W = 3;
  localparam int unsigned DEPTH  = 4;

  typedef logic [CORE_W+WIDTH-1:0] ent_t;

  logic clk = 1'b0;
  logic reset;

  div_rem_collect_if #(.WIDTH(WIDTH), .CORE_W(CORE_W), .DEPTH(DEPTH)) bus ();

  div_rem_collect #(.WIDTH(WIDTH), .CORE_W(CORE_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one-deep capture slot feeding a bounded queue.
  ent_t mq[$];
  bit   mcap_v = 1'b0;
  ent_t mcap;
  bit   movf   = 1'b0;
  bit   mpop;

  function automatic logic [WIDTH-1:0] fix(bit neg, logic [WIDTH-1:0] v);
    return neg ? WIDTH'(0) - v : v;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      mcap_v = 1'b0;
      movf   = 1'b0;
    end else begin
      mpop = (mq.size() != 0) && bus.resp_ready;
      if (mpop) void'(mq.pop_front());
      if (mcap_v) begin
        if (mq.size() < DEPTH) mq.push_back(mcap);
        else movf = 1'b1;
      end
      mcap_v = bus.ready_in;
      if (bus.ready_in)
        mcap = {bus.core_num_in,
                fix(bus.sign_state_in,
                    bus.rem_or_div_in ? bus.remainder_in : bus.quotient_in)};
    end
  end

  ent_t mh;
  always @(negedge clk) begin
    if (chk_en) begin
      mh = (mq.size() != 0) ? mq[0] : '0;
      chk("model_resp_valid", bus.resp_valid, 64'(mq.size() != 0));
      chk("model_resp_core", bus.resp_core, 64'(mh[CORE_W+WIDTH-1:WIDTH]));
      chk("model_resp_data", bus.resp_data, 64'(mh[WIDTH-1:0]));
      chk("model_count", bus.count, 64'(mq.size()));
      chk("model_full", bus.full, 64'(mq.size() == DEPTH));
      chk("model_overflow", bus.overflow, 64'(movf));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [CORE_W-1:0] core, bit rod, bit sgn,
                      logic [WIDTH-1:0] q, logic [WIDTH-1:0] r);
    bus.ready_in      = 1'b1;
    bus.core_num_in   = core;
    bus.rem_or_div_in = rod;
    bus.sign_state_in = sgn;
    bus.quotient_in   = q;
    bus.remainder_in  = r;
    step();
    bus.ready_in = 1'b0;
  endtask

  task automatic pop_expect(string nm, logic [CORE_W-1:0] core, logic [WIDTH-1:0] data);
    chk({nm, "_valid"}, bus.resp_valid, 64'd1);
    chk({nm, "_core"}, bus.resp_core, 64'(core));
    chk({nm, "_data"}, bus.resp_data, 64'(data));
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset             = 1'b1;
    bus.ready_in      = 1'b0;
    bus.rem_or_div_in = 1'b0;
    bus.sign_state_in = 1'b0;
    bus.core_num_in   = '0;
    bus.quotient_in   = '0;
    bus.remainder_in  = '0;
    bus.resp_ready    = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    reset = 1'b0;

    chk("rst_valid", bus.resp_valid, 64'd0);
    chk("rst_data", bus.resp_data, 64'd0);
    chk("rst_count", bus.count, 64'd0);
    chk("rst_full", bus.full, 64'd0);
    chk("rst_overflow", bus.overflow, 64'd0);

    // T1: two-cycle latency, then drained by an always-ready consumer
    bus.resp_ready = 1'b1;
    send(3'd5, 1'b0, 1'b0, 32'h0000_0007, 32'h3);
    chk("t1_not_yet", bus.resp_valid, 64'd0);
    step();
    chk("t1_valid", bus.resp_valid, 64'd1);
    chk("t1_core", bus.resp_core, 64'd5);
    chk("t1_data", bus.resp_data, 64'h7);
    step();
    chk("t1_count", bus.count, 64'd0);
    bus.resp_ready = 1'b0;

    // T2: sign fix on quotient, remainder and the most negative value
    send(3'd1, 1'b0, 1'b1, 32'h7, 32'h0);
    send(3'd2, 1'b1, 1'b1, 32'h0, 32'h3);
    send(3'd3, 1'b0, 1'b1, 32'h8000_0000, 32'h0);
    step();
    pop_expect("t2a", 3'd1, 32'hFFFF_FFF9);
    pop_expect("t2b", 3'd2, 32'hFFFF_FFFD);
    pop_expect("t2c", 3'd3, 32'h8000_0000);

    // T3: overfill by one, the fifth result is dropped
    for (int c = 1; c <= 5; c++) send(CORE_W'(c), 1'b0, 1'b0, 32'h100 + 32'(c), 32'h0);
    step();
    step();
    chk("t3_count", bus.count, 64'd4);
    chk("t3_full", bus.full, 64'd1);
    chk("t3_overflow", bus.overflow, 64'd1);
    for (int c = 1; c <= 4; c++) pop_expect("t3_drain", CORE_W'(c), 32'h100 + 32'(c));
    chk("t3_empty", bus.resp_valid, 64'd0);

    // T4: push and pop in the same cycle while full
    do_reset();
    for (int c = 1; c <= 4; c++) send(CORE_W'(c), 1'b0, 1'b0, 32'h200 + 32'(c), 32'h0);
    step();
    chk("t4_count_pre", bus.count, 64'd4);
    send(3'd6, 1'b0, 1'b0, 32'h206, 32'h0);
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    chk("t4_count", bus.count, 64'd4);
    chk("t4_overflow", bus.overflow, 64'd0);
    pop_expect("t4a", 3'd2, 32'h202);
    pop_expect("t4b", 3'd3, 32'h203);
    pop_expect("t4c", 3'd4, 32'h204);
    pop_expect("t4d", 3'd6, 32'h206);

    // T5: reset while a capture is in flight and two entries queued
    do_reset();
    send(3'd1, 1'b0, 1'b0, 32'h301, 32'h0);
    send(3'd2, 1'b0, 1'b0, 32'h302, 32'h0);
    step();
    chk("t5_count_pre", bus.count, 64'd2);
    send(3'd7, 1'b0, 1'b0, 32'h307, 32'h0);
    do_reset();
    chk("t5_valid", bus.resp_valid, 64'd0);
    chk("t5_count", bus.count, 64'd0);
    chk("t5_overflow", bus.overflow, 64'd0);
    repeat (3) step();
    chk("t5_never_valid", bus.resp_valid, 64'd0);
    chk("t5_never_count", bus.count, 64'd0);

    // T6: stalled head stays stable under incoming pushes
    send(3'd3, 1'b0, 1'b0, 32'h0000_CAFE, 32'h0);
    step();
    for (int i = 0; i < 10; i++) begin
      bus.ready_in      = 1'($urandom_range(0, 1));
      bus.core_num_in   = CORE_W'($urandom_range(0, 7));
      bus.rem_or_div_in = 1'($urandom_range(0, 1));
      bus.sign_state_in = 1'($urandom_range(0, 1));
      bus.quotient_in   = $urandom();
      bus.remainder_in  = $urandom();
      step();
      chk("t6_core", bus.resp_core, 64'd3);
      chk("t6_data", bus.resp_data, 64'h0000_CAFE);
    end
    bus.ready_in = 1'b0;

    // Randomized soak: early phase favours a slow consumer to keep the queue near full
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bus.ready_in      = 1'($urandom_range(0, 3) != 0);
      bus.core_num_in   = CORE_W'($urandom_range(0, 7));
      bus.rem_or_div_in = 1'($urandom_range(0, 1));
      bus.sign_state_in = 1'($urandom_range(0, 1));
      bus.quotient_in   = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom();
      bus.remainder_in  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom();
      bus.resp_ready    = (i < 1000) ? 1'($urandom_range(0, 3) == 0)
                                     : 1'($urandom_range(0, 3) != 0);
      reset             = 1'($urandom_range(0, 299) == 0);
      step();
    end
    reset          = 1'b0;
    bus.ready_in   = 1'b0;
    bus.resp_ready = 1'b1;
    repeat (8) step();
    chk("final_empty", bus.resp_valid, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
